// File: rtl/riscv_pkg.sv
// Shared RISC-V core types used by the memory stage.
package riscv_pkg;

  localparam int TAG_WIDTH = 3;

  typedef enum logic {
    LSU_OP_LD = 1'b0,
    LSU_OP_ST = 1'b1
  } lsu_op_e;

  // Encoded exactly as the load/store funct3 field
  typedef enum logic [2:0] {
    BYTE   = 3'b000,
    HALF   = 3'b001,
    WORD   = 3'b010,
    U_BYTE = 3'b100,
    U_HALF = 3'b101
  } lsu_dtype_e;

  typedef enum logic [1:0] {
    MEM_IDLE    = 2'd0,
    MEM_REQ     = 2'd1,
    MEM_WAIT_RV = 2'd2
  } mem_state_e;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and right-shift plus sign/zero extension for loads.
module lsu_align
  import riscv_pkg::*;
(
  input  lsu_dtype_e  st_dtype,
  input  logic [1:0]  st_offset,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata_lanes,
  input  lsu_dtype_e  ld_dtype,
  input  logic [1:0]  ld_offset,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [31:0] ld_shifted;

  always_comb begin
    st_be          = 4'b1111;
    st_wdata_lanes = st_wdata;
    case (st_dtype)
      BYTE, U_BYTE: begin
        st_be          = 4'b0001 << st_offset;
        st_wdata_lanes = {4{st_wdata[7:0]}};
      end
      HALF, U_HALF: begin
        st_be          = st_offset[1] ? 4'b1100 : 4'b0011;
        st_wdata_lanes = {2{st_wdata[15:0]}};
      end
      default: begin
        st_be          = 4'b1111;
        st_wdata_lanes = st_wdata;
      end
    endcase
  end

  // The addressed byte/half ends up in the low bits before extension
  always_comb begin
    ld_shifted = ld_rdata >> {ld_offset, 3'b000};
    case (ld_dtype)
      BYTE:    ld_data = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
      HALF:    ld_data = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
      U_BYTE:  ld_data = {24'd0, ld_shifted[7:0]};
      U_HALF:  ld_data = {16'd0, ld_shifted[15:0]};
      default: ld_data = ld_shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: single-outstanding req/gnt/rvalid data bus access and WB payload register.
// Define MEM_MISALIGN_EXC_EN to trap misaligned accesses instead of force-aligning them.
module mem_stage
  import riscv_pkg::*;
#(
  parameter int DATA_BUS_W = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush_M,
  input  logic                  ready_wb,
  output logic                  ready_mem,
  input  logic                  lsu_en_mem,
  input  lsu_op_e               lsu_op_mem,
  input  lsu_dtype_e            lsu_dtype_mem,
  input  logic [31:0]           lsu_addr_mem,
  input  logic [31:0]           lsu_wdata_mem,
  input  logic                  rd_wr_en_mem,
  input  logic [TAG_WIDTH-1:0]  rd_wr_tag_mem,
  input  logic [4:0]            rd_wr_addr_mem,
  input  logic [31:0]           rd_wr_data_mem,
  input  logic                  exc_taken_mem,
  input  logic [31:0]           pc_mem,
  output logic                  data_req,
  input  logic                  data_gnt,
  output logic                  data_we,
  output logic [3:0]            data_be,
  output logic [31:0]           data_addr,
  output logic [DATA_BUS_W-1:0] data_wdata,
  input  logic                  data_rvalid,
  input  logic [DATA_BUS_W-1:0] data_rdata,
  output logic                  rd_wr_en_wb,
  output logic [TAG_WIDTH-1:0]  rd_wr_tag_wb,
  output logic [4:0]            rd_wr_addr_wb,
  output logic [31:0]           rd_wr_data_wb,
  output logic                  exc_taken_wb,
  output logic [31:0]           pc_wb,
  output logic                  lsu_misalign_wb,
  output logic                  forward_mem_en,
  output logic [TAG_WIDTH-1:0]  forward_mem_tag,
  output logic [4:0]            forward_mem_addr,
  output logic [31:0]           forward_mem_wdata
);

  mem_state_e           state_q;
  logic [31:0]          eff_addr;
  logic                 misalign_trap;
  logic                 issue, idle_pass, rv_avail, killed;
  logic                 is_idle, is_req, is_wait;
  logic [3:0]           st_be;
  logic [31:0]          st_wdata, ld_data, load_val;

  logic [31:0]          addr_q, wdata_q, pc_q, buf_data_q;
  logic [3:0]           be_q;
  logic [1:0]           off_q;
  logic                 we_q, wb_en_q, killed_q, buf_valid_q;
  lsu_op_e              op_q;
  lsu_dtype_e           dtype_q;
  logic [TAG_WIDTH-1:0] tag_q;
  logic [4:0]           rd_addr_q;

`ifdef MEM_MISALIGN_EXC_EN
  always_comb begin
    case (lsu_dtype_mem)
      HALF, U_HALF: misalign_trap = lsu_addr_mem[0];
      WORD:         misalign_trap = |lsu_addr_mem[1:0];
      default:      misalign_trap = 1'b0;
    endcase
  end
  assign eff_addr = lsu_addr_mem;
`else
  // Without the trap, low address bits are silently dropped to the natural alignment
  always_comb begin
    case (lsu_dtype_mem)
      HALF, U_HALF: eff_addr = {lsu_addr_mem[31:1], 1'b0};
      WORD:         eff_addr = {lsu_addr_mem[31:2], 2'b00};
      default:      eff_addr = lsu_addr_mem;
    endcase
  end
  assign misalign_trap = 1'b0;
`endif

  assign is_idle   = (state_q == MEM_IDLE);
  assign is_req    = (state_q == MEM_REQ);
  assign is_wait   = (state_q == MEM_WAIT_RV);
  assign issue     = lsu_en_mem & ~exc_taken_mem & ~flush_M & ~misalign_trap;
  assign idle_pass = is_idle & ~issue;
  assign rv_avail  = is_wait & (data_rvalid | buf_valid_q);
  assign killed    = killed_q | flush_M;
  assign ready_mem = ready_wb & (idle_pass | rv_avail);

  lsu_align u_lsu_align (
    .st_dtype       (lsu_dtype_mem),
    .st_offset      (eff_addr[1:0]),
    .st_wdata       (lsu_wdata_mem),
    .st_be          (st_be),
    .st_wdata_lanes (st_wdata),
    .ld_dtype       (dtype_q),
    .ld_offset      (off_q),
    .ld_rdata       (data_rdata),
    .ld_data        (ld_data)
  );

  assign load_val = buf_valid_q ? buf_data_q : ld_data;

  // The request leaves combinationally in the issue cycle, then from captured copies
  assign data_req   = (is_idle & issue) | is_req;
  assign data_we    = is_idle ? (issue & (lsu_op_mem == LSU_OP_ST)) : we_q;
  assign data_be    = is_idle ? (issue ? st_be : 4'b0000) : be_q;
  assign data_addr  = is_idle ? (issue ? {eff_addr[31:2], 2'b00} : 32'd0) : addr_q;
  assign data_wdata = is_idle ? (issue ? st_wdata : 32'd0) : wdata_q;

  assign forward_mem_en    = is_idle ? (rd_wr_en_mem & ~lsu_en_mem & ~flush_M)
                                     : (rv_avail & (op_q == LSU_OP_LD) & wb_en_q & ~killed);
  assign forward_mem_tag   = is_idle ? rd_wr_tag_mem : tag_q;
  assign forward_mem_addr  = is_idle ? rd_wr_addr_mem : rd_addr_q;
  assign forward_mem_wdata = is_idle ? rd_wr_data_mem : load_val;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= MEM_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      off_q       <= '0;
      we_q        <= 1'b0;
      op_q        <= LSU_OP_LD;
      dtype_q     <= BYTE;
      wb_en_q     <= 1'b0;
      tag_q       <= '0;
      rd_addr_q   <= '0;
      pc_q        <= '0;
      killed_q    <= 1'b0;
      buf_valid_q <= 1'b0;
      buf_data_q  <= '0;
    end else begin
      case (state_q)
        MEM_IDLE: begin
          if (issue) begin
            addr_q      <= {eff_addr[31:2], 2'b00};
            off_q       <= eff_addr[1:0];
            we_q        <= (lsu_op_mem == LSU_OP_ST);
            be_q        <= st_be;
            wdata_q     <= st_wdata;
            op_q        <= lsu_op_mem;
            dtype_q     <= lsu_dtype_mem;
            wb_en_q     <= rd_wr_en_mem;
            tag_q       <= rd_wr_tag_mem;
            rd_addr_q   <= rd_wr_addr_mem;
            pc_q        <= pc_mem;
            killed_q    <= 1'b0;
            buf_valid_q <= 1'b0;
            state_q     <= data_gnt ? MEM_WAIT_RV : MEM_REQ;
          end
        end
        MEM_REQ: begin
          // A grant that coincides with a flush still has to be drained
          if (data_gnt) begin
            killed_q <= flush_M;
            state_q  <= MEM_WAIT_RV;
          end else if (flush_M) begin
            state_q <= MEM_IDLE;
          end
        end
        MEM_WAIT_RV: begin
          if (flush_M) killed_q <= 1'b1;
          if (data_rvalid && !buf_valid_q && !ready_wb) begin
            buf_valid_q <= 1'b1;
            buf_data_q  <= ld_data;
          end
          if (rv_avail && ready_wb) begin
            buf_valid_q <= 1'b0;
            state_q     <= MEM_IDLE;
          end
        end
        default: state_q <= MEM_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_wr_en_wb   <= 1'b0;
      rd_wr_tag_wb  <= '0;
      rd_wr_addr_wb <= '0;
      rd_wr_data_wb <= '0;
      exc_taken_wb  <= 1'b0;
      pc_wb         <= '0;
    end else if (ready_wb) begin
      if (idle_pass) begin
        rd_wr_en_wb   <= rd_wr_en_mem & ~lsu_en_mem & ~flush_M;
        rd_wr_tag_wb  <= rd_wr_tag_mem;
        rd_wr_addr_wb <= rd_wr_addr_mem;
        rd_wr_data_wb <= rd_wr_data_mem;
        exc_taken_wb  <= (exc_taken_mem | (lsu_en_mem & misalign_trap)) & ~flush_M;
        pc_wb         <= pc_mem;
      end else if (rv_avail) begin
        rd_wr_en_wb   <= (op_q == LSU_OP_LD) & wb_en_q & ~killed;
        rd_wr_tag_wb  <= tag_q;
        rd_wr_addr_wb <= rd_addr_q;
        rd_wr_data_wb <= load_val;
        exc_taken_wb  <= 1'b0;
        pc_wb         <= pc_q;
      end else begin
        rd_wr_en_wb  <= 1'b0;
        exc_taken_wb <= 1'b0;
      end
    end
  end

`ifdef MEM_MISALIGN_EXC_EN
  logic misalign_wb_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      misalign_wb_q <= 1'b0;
    end else if (ready_wb) begin
      misalign_wb_q <= idle_pass & lsu_en_mem & misalign_trap & ~exc_taken_mem & ~flush_M;
    end
  end

  assign lsu_misalign_wb = misalign_wb_q;
`else
  assign lsu_misalign_wb = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage: a vector table of single accesses plus multi-cycle corner sequences.
module tb_mem_stage;
  import riscv_pkg::*;

  logic                 clk;
  logic                 reset_n;
  logic                 flush_M, ready_wb, ready_mem;
  logic                 lsu_en_mem;
  lsu_op_e              lsu_op_mem;
  lsu_dtype_e           lsu_dtype_mem;
  logic [31:0]          lsu_addr_mem, lsu_wdata_mem;
  logic                 rd_wr_en_mem;
  logic [TAG_WIDTH-1:0] rd_wr_tag_mem;
  logic [4:0]           rd_wr_addr_mem;
  logic [31:0]          rd_wr_data_mem, pc_mem;
  logic                 exc_taken_mem;
  logic                 data_req, data_gnt, data_we, data_rvalid;
  logic [3:0]           data_be;
  logic [31:0]          data_addr, data_wdata, data_rdata;
  logic                 rd_wr_en_wb, exc_taken_wb, lsu_misalign_wb;
  logic [TAG_WIDTH-1:0] rd_wr_tag_wb, forward_mem_tag;
  logic [4:0]           rd_wr_addr_wb, forward_mem_addr;
  logic [31:0]          rd_wr_data_wb, pc_wb, forward_mem_wdata;
  logic                 forward_mem_en;

  int checks = 0;
  int errors = 0;

  mem_stage #(.DATA_BUS_W(32)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .flush_M           (flush_M),
    .ready_wb          (ready_wb),
    .ready_mem         (ready_mem),
    .lsu_en_mem        (lsu_en_mem),
    .lsu_op_mem        (lsu_op_mem),
    .lsu_dtype_mem     (lsu_dtype_mem),
    .lsu_addr_mem      (lsu_addr_mem),
    .lsu_wdata_mem     (lsu_wdata_mem),
    .rd_wr_en_mem      (rd_wr_en_mem),
    .rd_wr_tag_mem     (rd_wr_tag_mem),
    .rd_wr_addr_mem    (rd_wr_addr_mem),
    .rd_wr_data_mem    (rd_wr_data_mem),
    .exc_taken_mem     (exc_taken_mem),
    .pc_mem            (pc_mem),
    .data_req          (data_req),
    .data_gnt          (data_gnt),
    .data_we           (data_we),
    .data_be           (data_be),
    .data_addr         (data_addr),
    .data_wdata        (data_wdata),
    .data_rvalid       (data_rvalid),
    .data_rdata        (data_rdata),
    .rd_wr_en_wb       (rd_wr_en_wb),
    .rd_wr_tag_wb      (rd_wr_tag_wb),
    .rd_wr_addr_wb     (rd_wr_addr_wb),
    .rd_wr_data_wb     (rd_wr_data_wb),
    .exc_taken_wb      (exc_taken_wb),
    .pc_wb             (pc_wb),
    .lsu_misalign_wb   (lsu_misalign_wb),
    .forward_mem_en    (forward_mem_en),
    .forward_mem_tag   (forward_mem_tag),
    .forward_mem_addr  (forward_mem_addr),
    .forward_mem_wdata (forward_mem_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       lsu;
    lsu_op_e    op;
    lsu_dtype_e dt;
    logic [31:0] addr;
    logic [31:0] val;
    logic [31:0] rdata;
    logic        rd_en;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic        exp_wb_en;
    logic [31:0] exp_wb_data;
  } vec_t;

  vec_t vecs[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idleInputs();
    lsu_en_mem     = 1'b0;
    lsu_op_mem     = LSU_OP_LD;
    lsu_dtype_mem  = WORD;
    lsu_addr_mem   = '0;
    lsu_wdata_mem  = '0;
    rd_wr_en_mem   = 1'b0;
    rd_wr_tag_mem  = '0;
    rd_wr_addr_mem = '0;
    rd_wr_data_mem = '0;
    exc_taken_mem  = 1'b0;
    pc_mem         = '0;
    flush_M        = 1'b0;
    ready_wb       = 1'b1;
    data_gnt       = 1'b0;
    data_rvalid    = 1'b0;
    data_rdata     = '0;
  endtask

  task automatic driveAccess(input lsu_op_e op, input lsu_dtype_e dt, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic rd_en, input logic [4:0] rd);
    lsu_en_mem     = 1'b1;
    lsu_op_mem     = op;
    lsu_dtype_mem  = dt;
    lsu_addr_mem   = addr;
    lsu_wdata_mem  = wdata;
    rd_wr_en_mem   = rd_en;
    rd_wr_addr_mem = rd;
    rd_wr_tag_mem  = 3'd1;
    pc_mem         = 32'h0000_0200;
  endtask

  // One table entry: issue with same-cycle grant, rvalid the next cycle, then inspect WB
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    if (v.lsu) begin
      driveAccess(v.op, v.dt, v.addr, v.val, v.rd_en, 5'd7);
    end else begin
      rd_wr_en_mem   = v.rd_en;
      rd_wr_addr_mem = 5'd5;
      rd_wr_data_mem = v.val;
    end
    data_gnt = 1'b1;
    #1;
    checkOutput({v.name, "/data_req"}, 32'(data_req), 32'(v.lsu));
    if (v.lsu) begin
      checkOutput({v.name, "/data_addr"}, data_addr, v.exp_addr);
      checkOutput({v.name, "/data_be"}, 32'(data_be), 32'(v.exp_be));
      checkOutput({v.name, "/data_we"}, 32'(data_we), 32'(v.op == LSU_OP_ST));
      if (v.op == LSU_OP_ST) checkOutput({v.name, "/data_wdata"}, data_wdata, v.exp_wdata);
      checkOutput({v.name, "/ready_issue"}, 32'(ready_mem), 32'd0);
      @(negedge clk);
      data_gnt    = 1'b0;
      data_rvalid = 1'b1;
      data_rdata  = v.rdata;
      #1;
      checkOutput({v.name, "/ready_rv"}, 32'(ready_mem), 32'd1);
      checkOutput({v.name, "/fwd_en"}, 32'(forward_mem_en), 32'(v.exp_wb_en));
      if (v.exp_wb_en) checkOutput({v.name, "/fwd_data"}, forward_mem_wdata, v.exp_wb_data);
    end else begin
      checkOutput({v.name, "/fwd_en"}, 32'(forward_mem_en), 32'(v.exp_wb_en));
      checkOutput({v.name, "/ready"}, 32'(ready_mem), 32'd1);
    end
    @(negedge clk);
    idleInputs();
    #1;
    checkOutput({v.name, "/wb_en"}, 32'(rd_wr_en_wb), 32'(v.exp_wb_en));
    if (v.exp_wb_en) checkOutput({v.name, "/wb_data"}, rd_wr_data_wb, v.exp_wb_data);
  endtask

  initial begin
    vecs.push_back('{"alu_wr",  1'b0, LSU_OP_LD, WORD,   32'h0,    32'h0000_1234, 32'h0,         1'b1, 32'h0,    4'b0000, 32'h0,         1'b1, 32'h0000_1234});
    vecs.push_back('{"alu_nowr",1'b0, LSU_OP_LD, WORD,   32'h0,    32'h0000_DEAD, 32'h0,         1'b0, 32'h0,    4'b0000, 32'h0,         1'b0, 32'h0});
    vecs.push_back('{"lb",      1'b1, LSU_OP_LD, BYTE,   32'h1003, 32'h0,         32'h80FF_FFFF, 1'b1, 32'h1000, 4'b1000, 32'h0,         1'b1, 32'hFFFF_FF80});
    vecs.push_back('{"lbu",     1'b1, LSU_OP_LD, U_BYTE, 32'h1001, 32'h0,         32'h1234_80AB, 1'b1, 32'h1000, 4'b0010, 32'h0,         1'b1, 32'h0000_0080});
    vecs.push_back('{"lh",      1'b1, LSU_OP_LD, HALF,   32'h1002, 32'h0,         32'h8001_0000, 1'b1, 32'h1000, 4'b1100, 32'h0,         1'b1, 32'hFFFF_8001});
    vecs.push_back('{"lhu",     1'b1, LSU_OP_LD, U_HALF, 32'h1000, 32'h0,         32'h1234_F00D, 1'b1, 32'h1000, 4'b0011, 32'h0,         1'b1, 32'h0000_F00D});
    vecs.push_back('{"lw",      1'b1, LSU_OP_LD, WORD,   32'h1004, 32'h0,         32'hCAFE_BABE, 1'b1, 32'h1004, 4'b1111, 32'h0,         1'b1, 32'hCAFE_BABE});
    vecs.push_back('{"sb",      1'b1, LSU_OP_ST, BYTE,   32'h3001, 32'h0000_005A, 32'h0,         1'b0, 32'h3000, 4'b0010, 32'h5A5A_5A5A, 1'b0, 32'h0});
    vecs.push_back('{"sh",      1'b1, LSU_OP_ST, HALF,   32'h2002, 32'h0000_ABCD, 32'h0,         1'b0, 32'h2000, 4'b1100, 32'hABCD_ABCD, 1'b0, 32'h0});
    vecs.push_back('{"sw",      1'b1, LSU_OP_ST, WORD,   32'h2008, 32'h1122_3344, 32'h0,         1'b0, 32'h2008, 4'b1111, 32'h1122_3344, 1'b0, 32'h0});

    idleInputs();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset/data_req", 32'(data_req), 32'd0);
    checkOutput("reset/data_be", 32'(data_be), 32'd0);
    checkOutput("reset/wb_en", 32'(rd_wr_en_wb), 32'd0);
    checkOutput("reset/exc", 32'(exc_taken_wb), 32'd0);
    checkOutput("reset/pc_wb", pc_wb, 32'd0);
    checkOutput("reset/ready", 32'(ready_mem), 32'd1);
    reset_n = 1'b1;

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // LB with the grant held off for two cycles
    @(negedge clk);
    driveAccess(LSU_OP_LD, BYTE, 32'h1003, 32'h0, 1'b1, 5'd9);
    for (int c = 0; c < 3; c++) begin
      if (c == 2) data_gnt = 1'b1;
      #1;
      checkOutput($sformatf("lbdly/req%0d", c), 32'(data_req), 32'd1);
      checkOutput($sformatf("lbdly/addr%0d", c), data_addr, 32'h1000);
      checkOutput($sformatf("lbdly/ready%0d", c), 32'(ready_mem), 32'd0);
      @(negedge clk);
    end
    data_gnt = 1'b0;
    #1;
    checkOutput("lbdly/wait_req", 32'(data_req), 32'd0);
    checkOutput("lbdly/wait_ready", 32'(ready_mem), 32'd0);
    @(negedge clk);
    data_rvalid = 1'b1;
    data_rdata  = 32'h80FF_FFFF;
    #1;
    checkOutput("lbdly/rv_ready", 32'(ready_mem), 32'd1);
    checkOutput("lbdly/fwd_data", forward_mem_wdata, 32'hFFFF_FF80);
    @(negedge clk);
    idleInputs();
    #1;
    checkOutput("lbdly/wb_en", 32'(rd_wr_en_wb), 32'd1);
    checkOutput("lbdly/wb_data", rd_wr_data_wb, 32'hFFFF_FF80);
    checkOutput("lbdly/wb_addr", 32'(rd_wr_addr_wb), 32'd9);

    // Flush while waiting for rvalid: the access drains but WB sees nothing
    @(negedge clk);
    driveAccess(LSU_OP_LD, WORD, 32'h3000, 32'h0, 1'b1, 5'd4);
    data_gnt = 1'b1;
    @(negedge clk);
    data_gnt = 1'b0;
    flush_M  = 1'b1;
    #1;
    checkOutput("flushrv/ready_fl", 32'(ready_mem), 32'd0);
    @(negedge clk);
    flush_M = 1'b0;
    #1;
    checkOutput("flushrv/still_wait", 32'(ready_mem), 32'd0);
    @(negedge clk);
    data_rvalid = 1'b1;
    data_rdata  = 32'h0000_0055;
    #1;
    checkOutput("flushrv/ready_rv", 32'(ready_mem), 32'd1);
    checkOutput("flushrv/fwd_en", 32'(forward_mem_en), 32'd0);
    @(negedge clk);
    idleInputs();
    #1;
    checkOutput("flushrv/wb_en", 32'(rd_wr_en_wb), 32'd0);

    // rvalid while WB is stalled: data must survive until WB accepts
    @(negedge clk);
    driveAccess(LSU_OP_LD, HALF, 32'h4000, 32'h0, 1'b1, 5'd12);
    data_gnt = 1'b1;
    @(negedge clk);
    data_gnt    = 1'b0;
    data_rvalid = 1'b1;
    data_rdata  = 32'h0000_8765;
    ready_wb    = 1'b0;
    #1;
    checkOutput("stall/ready_rv", 32'(ready_mem), 32'd0);
    @(negedge clk);
    data_rvalid = 1'b0;
    data_rdata  = 32'hFFFF_0000;
    #1;
    checkOutput("stall/ready_hold", 32'(ready_mem), 32'd0);
    checkOutput("stall/wb_hold", 32'(rd_wr_en_wb), 32'd0);
    @(negedge clk);
    ready_wb = 1'b1;
    #1;
    checkOutput("stall/ready_go", 32'(ready_mem), 32'd1);
    checkOutput("stall/fwd_data", forward_mem_wdata, 32'hFFFF_8765);
    @(negedge clk);
    idleInputs();
    #1;
    checkOutput("stall/wb_en", 32'(rd_wr_en_wb), 32'd1);
    checkOutput("stall/wb_data", rd_wr_data_wb, 32'hFFFF_8765);

    // Flush in REQ before the grant drops the request
    @(negedge clk);
    driveAccess(LSU_OP_LD, WORD, 32'h5000, 32'h0, 1'b1, 5'd3);
    @(negedge clk);
    flush_M = 1'b1;
    #1;
    checkOutput("flushreq/req", 32'(data_req), 32'd1);
    @(negedge clk);
    idleInputs();
    #1;
    checkOutput("flushreq/dropped", 32'(data_req), 32'd0);
    checkOutput("flushreq/ready", 32'(ready_mem), 32'd1);

    // Reset pulse in REQ, then a stray rvalid
    @(negedge clk);
    rd_wr_en_mem   = 1'b1;
    rd_wr_data_mem = 32'hA5A5_A5A5;
    pc_mem         = 32'h0000_0600;
    @(negedge clk);
    driveAccess(LSU_OP_LD, WORD, 32'h6000, 32'h0, 1'b1, 5'd8);
    @(negedge clk);
    #1;
    checkOutput("rstreq/req", 32'(data_req), 32'd1);
    checkOutput("rstreq/wb_data_pre", rd_wr_data_wb, 32'hA5A5_A5A5);
    #1;
    idleInputs();
    reset_n = 1'b0;
    #1;
    checkOutput("rstreq/req_async", 32'(data_req), 32'd0);
    checkOutput("rstreq/wb_data", rd_wr_data_wb, 32'd0);
    checkOutput("rstreq/pc_wb", pc_wb, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    data_rvalid = 1'b1;
    data_rdata  = 32'h0000_DEAD;
    #1;
    checkOutput("rstreq/late_fwd", 32'(forward_mem_en), 32'd0);
    checkOutput("rstreq/late_ready", 32'(ready_mem), 32'd1);
    @(negedge clk);
    idleInputs();
    #1;
    checkOutput("rstreq/late_wb", 32'(rd_wr_en_wb), 32'd0);

    // Misaligned LW at 0x2001
    @(negedge clk);
    driveAccess(LSU_OP_LD, WORD, 32'h2001, 32'h0, 1'b1, 5'd6);
    data_gnt = 1'b1;
    #1;
`ifdef MEM_MISALIGN_EXC_EN
    checkOutput("misal/req", 32'(data_req), 32'd0);
    checkOutput("misal/ready", 32'(ready_mem), 32'd1);
    @(negedge clk);
    idleInputs();
    #1;
    checkOutput("misal/flag", 32'(lsu_misalign_wb), 32'd1);
    checkOutput("misal/exc", 32'(exc_taken_wb), 32'd1);
    checkOutput("misal/wb_en", 32'(rd_wr_en_wb), 32'd0);
`else
    checkOutput("misal/req", 32'(data_req), 32'd1);
    checkOutput("misal/addr", data_addr, 32'h2000);
    @(negedge clk);
    data_gnt    = 1'b0;
    data_rvalid = 1'b1;
    data_rdata  = 32'h0BAD_F00D;
    @(negedge clk);
    idleInputs();
    #1;
    checkOutput("misal/wb_data", rd_wr_data_wb, 32'h0BAD_F00D);
    checkOutput("misal/flag", 32'(lsu_misalign_wb), 32'd0);
    checkOutput("misal/exc", 32'(exc_taken_wb), 32'd0);
`endif

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
